// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake, discards stale fetches after a redirect.
// Optional misaligned-redirect trap is enabled with `define IF_ALIGN_CHECK_EN (default build forces word alignment).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        id_shouldStall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_target,
  input  logic        exceptClear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        if_addrErr
);

  typedef enum logic [1:0] {FETCH, READY, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ibuf;
  logic        addr_err;
  logic        take;
  logic        jmp;
  logic        req_pending;
  logic [31:0] jmp_pc;

  assign take = cpu_en & ~id_shouldStall;
  assign jmp  = take & id_shouldJumpOrBranch;
  // A request is still in flight if we are in FETCH or DISCARD and its ack has not arrived yet.
  assign req_pending = ~imem_ack & (state != READY);

`ifdef IF_ALIGN_CHECK_EN
  assign jmp_pc = id_target;
`else
  assign jmp_pc   = id_target & 32'hFFFF_FFFC;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      ibuf  <= 32'h0;
      state <= FETCH;
`ifdef IF_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else if (exceptClear) begin
      pc    <= EXC_VECTOR;
      ibuf  <= 32'h0;
      state <= req_pending ? DISCARD : FETCH;
`ifdef IF_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else if (!addr_err) begin
      if (jmp) begin
        pc   <= jmp_pc;
        ibuf <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
        if (|id_target[1:0]) begin
          state    <= READY;
          addr_err <= 1'b1;
        end else
`endif
        state <= req_pending ? DISCARD : FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (imem_ack) begin
              if (take) begin
                pc <= pc + 32'd4;
              end else begin
                ibuf  <= imem_rdata;
                state <= READY;
              end
            end
          end
          READY: begin
            if (take) begin
              pc    <= pc + 32'd4;
              state <= FETCH;
            end
          end
          DISCARD: begin
            if (imem_ack) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign imem_req       = (state == FETCH);
  assign imem_addr      = pc;
  assign if_pc_4        = pc + 32'd4;
  assign if_valid       = ((state == READY) & ~addr_err) | ((state == FETCH) & imem_ack);
  assign if_instruction = (state == READY) ? ibuf :
                          ((state == FETCH) & imem_ack) ? imem_rdata : 32'h0;
  assign if_addrErr     = addr_err;

endmodule
